// File: rtl/gaussian3x3_stream_if.sv
// Stream bundle for the 3x3 Gaussian blur stage: the input pixel stream and
// the filtered output stream. The out_TLAST wire exists only when
// GAUSS_TLAST_EN is defined.
interface gaussian3x3_stream_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] in_TDATA;
    logic                  in_TVALID;
    logic                  in_TREADY;
    logic [DATA_WIDTH-1:0] out_TDATA;
    logic                  out_TVALID;
    logic                  out_TREADY;
`ifdef GAUSS_TLAST_EN
    logic                  out_TLAST;

    // Traffic source/sink side (upstream producer plus downstream consumer)
    modport master (
        output in_TDATA, in_TVALID, out_TREADY,
        input  in_TREADY, out_TDATA, out_TVALID, out_TLAST
    );

    // Filter side
    modport slave (
        input  in_TDATA, in_TVALID, out_TREADY,
        output in_TREADY, out_TDATA, out_TVALID, out_TLAST
    );
`else
    // Traffic source/sink side (upstream producer plus downstream consumer)
    modport master (
        output in_TDATA, in_TVALID, out_TREADY,
        input  in_TREADY, out_TDATA, out_TVALID
    );

    // Filter side
    modport slave (
        input  in_TDATA, in_TVALID, out_TREADY,
        output in_TREADY, out_TDATA, out_TVALID
    );
`endif
endinterface

// File: rtl/gaussian3x3_stream.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1]/16, round to nearest).
// Raster-order input, one pixel per handshake; emits only the valid region
// ((IMG_WIDTH-2) x (IMG_HEIGHT-2) pixels) one cycle after the pixel that
// completes each window. A single output register backs the stream, so
// in_TREADY is simply "output register free or being drained".
// Optional: define GAUSS_TLAST_EN to add out_TLAST on the last output of a frame.
module gaussian3x3_stream #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 20,
    parameter int IMG_HEIGHT = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    gaussian3x3_stream_if.slave   bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int SW = DATA_WIDTH + 4;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] w   [3][3];
    logic [DATA_WIDTH-1:0] nc  [3];
    logic [SW-1:0]         sum;
    logic [DATA_WIDTH-1:0] filt;
    logic                  acc;
    logic                  emit;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    assign bus.in_TREADY  = !out_valid || bus.out_TREADY;
    assign acc            = bus.in_TVALID && bus.in_TREADY;
    assign emit           = acc && (row >= RW'(2)) && (col >= CW'(2));
    assign bus.out_TVALID = out_valid;
    assign bus.out_TDATA  = out_data;

    // Incoming right-hand column, top to bottom, from the pre-update buffers
    assign nc[0] = lb1[col];
    assign nc[1] = lb0[col];
    assign nc[2] = bus.in_TDATA;

    // Kernel applied to the window as it will look after this pixel's shift
    assign sum = SW'(w[0][1])        + (SW'(w[0][2]) << 1) + SW'(nc[0])
               + (SW'(w[1][1]) << 1) + (SW'(w[1][2]) << 2) + (SW'(nc[1]) << 1)
               + SW'(w[2][1])        + (SW'(w[2][2]) << 1) + SW'(nc[2]);
    assign filt = DATA_WIDTH'((sum + SW'(8)) >> 4);

    // Line buffers and window; contents need no reset since row/col gate emission
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.in_TDATA;
            for (int r = 0; r < 3; r++) begin
                w[r][0] <= w[r][1];
                w[r][1] <= w[r][2];
                w[r][2] <= nc[r];
            end
        end
    end

    // Raster position counters and the single output register
    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (acc) begin
                if (col == CW'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= filt;
            end else if (bus.out_TREADY) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef GAUSS_TLAST_EN
    logic out_last;
    assign bus.out_TLAST = out_last;

    // End-of-frame flag travels with the data word and holds under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            out_last <= 1'b0;
        end else if (emit) begin
            out_last <= (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
        end
    end
`endif
endmodule

// File: tb/tb_gaussian3x3_stream.sv
// Self-checking bench for gaussian3x3_stream (20x20 frames, 12-bit pixels).
// A frame-image model computes every expected output from the kernel
// definition; a per-cycle compare process checks handshakes against it, and
// per-test literal expectations pin the model itself.
module tb_gaussian3x3_stream;
    localparam int DW   = 12;
    localparam int W    = 20;
    localparam int H    = 20;
    localparam int NOUT = (W - 2) * (H - 2);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gaussian3x3_stream_if #(.DATA_WIDTH(DW)) bus ();

    gaussian3x3_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t  exp_q[$];
    int    got[$];
    bit    got_last[$];
    int    img[H][W];
    int    pr = 0, pc = 0;
    int    checks = 0, errors = 0;
    int    rmode = 0;
    bit    gaps = 0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference blur of the 3x3 neighbourhood whose bottom-right is (r,c)
    function automatic int blur(int r, int c);
        int s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1) * img[r-2+dr][c-2+dc];
        return (s + 8) / 16;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 random, 2 stalled
    initial begin
        bus.out_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.out_TREADY = 1'b1;
                1:       bus.out_TREADY = 1'($urandom_range(0, 1));
                default: bus.out_TREADY = 1'b0;
            endcase
        end
    end

    // Per-cycle output checker
    int              held_v = 0;
    logic [DW-1:0]   held_d;
    logic            held_l;
    initial begin
        exp_t e;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 0;
            end else begin
                chk("in_ready_rule", int'(bus.in_TREADY), int'(!bus.out_TVALID || bus.out_TREADY));
                if (held_v != 0 && bus.out_TVALID) begin
                    chk("hold_data", int'(bus.out_TDATA), int'(held_d));
`ifdef GAUSS_TLAST_EN
                    chk("hold_last", int'(bus.out_TLAST), int'(held_l));
`endif
                end
                held_v = (bus.out_TVALID && !bus.out_TREADY) ? 1 : 0;
                held_d = bus.out_TDATA;
`ifdef GAUSS_TLAST_EN
                held_l = bus.out_TLAST;
`endif
                if (bus.out_TVALID && bus.out_TREADY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(bus.out_TDATA), e.data);
`ifdef GAUSS_TLAST_EN
                        chk("out_last", int'(bus.out_TLAST), int'(e.last));
`endif
                    end
                    got.push_back(int'(bus.out_TDATA));
`ifdef GAUSS_TLAST_EN
                    got_last.push_back(bus.out_TLAST);
`else
                    got_last.push_back(1'b0);
`endif
                end
            end
        end
    end

    task automatic send_px(int p);
        int t = 0;
        exp_t e;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_TVALID = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_TVALID = 1'b1;
        bus.in_TDATA  = DW'(p);
        while (1) begin
            @(negedge clk);
            if (bus.in_TREADY) break;
            t++;
            if (t > 2000) begin
                chk("accept_timeout", 0, 1);
                bus.in_TVALID = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.in_TVALID = 1'b0;
        img[pr][pc] = p;
        if (pr >= 2 && pc >= 2) begin
            e.data = blur(pr, pc);
            e.last = (pr == H - 1) && (pc == W - 1);
            exp_q.push_back(e);
            chk("latency_valid", int'(bus.out_TVALID), 1);
            chk("latency_data", int'(bus.out_TDATA), e.data);
        end
        if (pc == W - 1) begin
            pc = 0;
            pr = (pr == H - 1) ? 0 : pr + 1;
        end else begin
            pc++;
        end
    endtask

    // kind: 0 constant, 1 impulse at (2,2), 2 ramp row*W+col, 3 random
    task automatic send_frame(int kind, int val, int npx);
        for (int i = 0; i < npx; i++) begin
            int r = i / W;
            int c = i % W;
            int p;
            case (kind)
                0:       p = val;
                1:       p = (r == 2 && c == 2) ? val : 0;
                2:       p = r * W + c;
                default: p = int'($urandom_range(0, 4095));
            endcase
            send_px(p);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.out_TVALID) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        exp_q.delete();
        pr = 0;
        pc = 0;
        repeat (n) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(bus.out_TVALID), 0);
        chk("reset_out_data", int'(bus.out_TDATA), 0);
        chk("reset_in_ready", int'(bus.in_TREADY), 1);
`ifdef GAUSS_TLAST_EN
        chk("reset_out_last", int'(bus.out_TLAST), 0);
`endif
        reset = 1'b0;
    endtask

    task automatic clear_got();
        got.delete();
        got_last.delete();
    endtask

    task automatic chk_all(string name, int lo, int hi, int val);
        for (int i = lo; i < hi && i < got.size(); i++) chk(name, got[i], val);
    endtask

    task automatic chk_nonzero(string name, int seq[9]);
        int nz[$];
        foreach (got[i]) if (got[i] != 0) nz.push_back(got[i]);
        chk({name, "_count"}, nz.size(), 9);
        for (int i = 0; i < 9 && i < nz.size(); i++) chk(name, nz[i], seq[i]);
    endtask

    initial begin
        int imp16[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int imp8[9]  = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
        bus.in_TVALID = 1'b0;
        bus.in_TDATA  = '0;
        do_reset(3);

        // Constant frame, no stalls: every output is 100
        rmode = 0; gaps = 0; clear_got();
        send_frame(0, 100, W * H); drain();
        chk("const_count", got.size(), NOUT);
        chk_all("const_val", 0, NOUT, 100);

        // Impulse of 16 then 8 at (2,2)
        clear_got();
        send_frame(1, 16, W * H); drain();
        chk("imp16_count", got.size(), NOUT);
        chk_nonzero("imp16", imp16);
        clear_got();
        send_frame(1, 8, W * H); drain();
        chk_nonzero("imp8", imp8);

        // Full-scale frame with random downstream stalls
        rmode = 1; clear_got();
        send_frame(0, 4095, W * H); drain();
        chk("max_count", got.size(), NOUT);
        chk_all("max_val", 0, NOUT, 4095);

        // Ramp frame with a long stall after the first output
        rmode = 2; clear_got();
        fork
            send_frame(2, 0, W * H);
            begin
                int t = 0;
                while (!bus.out_TVALID && t < 2000) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                repeat (10) @(posedge clk);
                #1;
                chk("bp_valid_held", int'(bus.out_TVALID), 1);
                chk("bp_in_ready_low", int'(bus.in_TREADY), 0);
                chk("bp_first_data", int'(bus.out_TDATA), 21);
                rmode = 1;
            end
        join
        drain();
        chk("ramp_count", got.size(), NOUT);
        for (int i = 0; i < got.size() && i < NOUT; i++)
            chk("ramp_centre", got[i], (1 + i / (W - 2)) * W + 1 + i % (W - 2));

        // Random pixels, input gaps and output stalls
        gaps = 1; clear_got();
        send_frame(3, 0, W * H); drain();
        chk("rand_count", got.size(), NOUT);

        // Reset 30 pixels into a frame, then a clean frame of 50
        send_frame(2, 0, 30);
        do_reset(2);
        clear_got();
        send_frame(0, 50, W * H); drain();
        chk("rst_count", got.size(), NOUT);
        chk_all("rst_val", 0, NOUT, 50);

        // Back-to-back frames of 10 then 20
        gaps = 0; clear_got();
        send_frame(0, 10, W * H);
        send_frame(0, 20, W * H); drain();
        chk("b2b_count", got.size(), 2 * NOUT);
        chk_all("b2b_first", 0, NOUT, 10);
        chk_all("b2b_second", NOUT, 2 * NOUT, 20);
`ifdef GAUSS_TLAST_EN
        begin
            int nl = 0;
            foreach (got_last[i]) nl += int'(got_last[i]);
            chk("b2b_last_total", nl, 2);
            if (got_last.size() == 2 * NOUT) begin
                chk("b2b_last_1", int'(got_last[NOUT-1]), 1);
                chk("b2b_last_2", int'(got_last[2*NOUT-1]), 1);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case a handshake never completes
    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gaussian3x3_stream.md
Name: gaussian3x3_stream

Overview:
- Streaming 3x3 Gaussian blur stage directly downstream of the crop FIFO.
- Consumes a cropped image in raster order, one pixel per handshake, over a ready/valid interface.
- Emits the "valid" convolution only: (IMG_WIDTH-2) x (IMG_HEIGHT-2) output pixels per frame, in raster order.
- Kernel is [1 2 1; 2 4 2; 1 2 1]/16, rounded to nearest.

Parameters:
- DATA_WIDTH, 12: pixel width in bits, input and output.
- IMG_WIDTH, 20: pixels per input row; minimum 3.
- IMG_HEIGHT, 20: rows per input frame; minimum 3.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_TDATA  input  DATA_WIDTH  input pixel.
- in_TVALID  input  1  upstream has a pixel.
- in_TREADY  output  1  block accepts a pixel this cycle.
- out_TDATA  output  DATA_WIDTH  filtered pixel.
- out_TVALID  output  1  out_TDATA holds an unconsumed result.
- out_TREADY  input  1  downstream accepts.
- out_TLAST  output  1  last output pixel of frame; present only with GAUSS_TLAST_EN.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Handshakes:
  - Input accept: acc = in_TVALID && in_TREADY.
  - Output handshake: out_TVALID && out_TREADY.
  - in_TREADY = !out_TVALID || out_TREADY (combinational). It is a single output register, so there is no skid buffer.
- Position counters:
  - col: 0..IMG_WIDTH-1; row: 0..IMG_HEIGHT-1.
  - Both advance on acc only.
  - col wraps to 0 and increments row. At col=IMG_WIDTH-1, row=IMG_HEIGHT-1 both wrap to 0, so the next pixel starts a new frame.
- Line buffers:
  - Two arrays lb0 and lb1, each IMG_WIDTH x DATA_WIDTH, indexed by col.
  - On acc: lb1[col] <= lb0[col]; lb0[col] <= in_TDATA.
- Window:
  - 3x3 register array w[r][c], with c=2 the newest column.
  - On acc: the window shifts left by one column. The new right column is {lb1[col], lb0[col], in_TDATA}, top to bottom, using the pre-update buffer values.
- Arithmetic:
  - sum = w00 + 2w01 + w02 + 2w10 + 4w11 + 2w12 + w20 + 2w21 + w22, computed on the post-shift window.
  - sum is DATA_WIDTH+4 bits, with no overflow.
  - out = (sum + 8) >> 4, always <= 2^DATA_WIDTH-1, so no saturation is needed.
- Output emission:
  - An accepted pixel at (row>=2, col>=2) produces one output, centred at (row-1, col-1).
  - out_TDATA and out_TVALID are registered at the next clock edge, giving 1-cycle latency.
  - Pixels with row<2 or col<2 are accepted and stored but produce no output.
- Output register update at each edge:
  - If acc with output due: out_TVALID <= 1 and out_TDATA loads.
  - Else if out_TREADY: out_TVALID <= 0.
  - Else hold. out_TDATA stays stable while out_TVALID=1 && !out_TREADY.
- Simultaneous events: output consumed and a new result loaded in the same cycle gives full throughput, 1 pixel/cycle.
- Reset values: out_TVALID=0, out_TDATA=0, out_TLAST=0, row=0, col=0. Window and line buffers are not cleared; the row/col gating makes their contents irrelevant.
- Reset mid-frame: partial frame discarded, any pending output dropped. The next accepted pixel is treated as (0,0).
- Frames run back-to-back with no gap cycles required. Rows 0-1 of a new frame never emit outputs, so no stale-row mixing occurs.

Optional Feature:
- Macro GAUSS_TLAST_EN.
- Defined:
  - out_TLAST port exists.
  - out_TLAST is registered alongside out_TDATA.
  - It is 1 exactly for the output generated by input (IMG_HEIGHT-1, IMG_WIDTH-1), else 0.
  - It holds under backpressure and resets to 0.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Constant frame: IMG_WIDTH=IMG_HEIGHT=4, all pixels 100, out_TREADY=1 -> exactly 4 outputs, all 100. Each output appears 1 cycle after inputs (2,2), (2,3), (3,2), (3,3) are accepted.
- Impulse: 5x5 frame of zeros with pixel (2,2)=16 -> 9 outputs in raster order: 1,2,1,2,4,2,1,2,1. With (2,2)=8 instead, the centre output is (32+8)>>4 = 2.
- Max value: 5x5 frame all 4095 -> 9 outputs all 4095, no wrap.
- Backpressure on a 20x20 ramp frame:
  - Stimulus: pixel = row*20+col; hold out_TREADY=0 after the first output.
  - Required: in_TREADY drops to 0; out_TDATA is held; no input is lost.
  - Random out_TREADY toggling -> 324 outputs, each equal to the centre value (row-1)*20+(col-1) of its window.
- Reset mid-frame: assert reset after 30 pixels of a 20x20 frame, then send a full frame of 50 -> out_TVALID=0 during reset; exactly 324 outputs of 50 follow.
- Back-to-back frames with GAUSS_TLAST_EN: two 4x4 frames sent, the first all 10 and the second all 20 -> 4 outputs of 10 then 4 of 20. out_TLAST=1 only on the 4th and 8th outputs.
